// File: rtl/sram_ctrl_sync.sv
// Clocked controller for an asynchronous single-port SRAM: one request at a time,
// CE/OE/WE and the data bus sequenced by programmable wait-state counts.

// Protocol checker: bus contention, strobe exclusivity and response pulse shape.
module sram_ctrl_sync_chk (
  input logic clk,
  input logic rst,
  input logic ce_n,
  input logic oe_n,
  input logic we_n,
  input logic drive,
  input logic rsp_valid,
  input logic ready,
  input logic busy
);

  a_no_bus_fight: assert property (@(posedge clk) disable iff (rst) !(!oe_n && drive));
  a_oe_we_excl:   assert property (@(posedge clk) disable iff (rst) !(!oe_n && !we_n));
  a_drive_in_ce:  assert property (@(posedge clk) disable iff (rst) drive |-> !ce_n);
  a_rsp_pulse:    assert property (@(posedge clk) disable iff (rst) rsp_valid |=> !rsp_valid);
  a_ready_idle:   assert property (@(posedge clk) disable iff (rst) ready |-> !busy);

endmodule

module sram_ctrl_sync #(
  parameter int DATA_W   = 16,
  parameter int ADDR_W   = 18,
  parameter int T_WSETUP = 1,
  parameter int T_WPULSE = 2,
  parameter int T_WHOLD  = 1,
  parameter int T_RACC   = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_we,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [DATA_W-1:0] req_wdata,
  output logic              rsp_valid,
  output logic [DATA_W-1:0] rsp_rdata,
  output logic              busy,
  output logic              sram_ce_n,
  output logic              sram_oe_n,
  output logic              sram_we_n,
  output logic [ADDR_W-1:0] sram_addr,
  inout  wire  [DATA_W-1:0] sram_data
);

  // A zero wait-state count would make a phase vanish, so it is clamped to one cycle.
  localparam int WS = (T_WSETUP < 1) ? 1 : T_WSETUP;
  localparam int WP = (T_WPULSE < 1) ? 1 : T_WPULSE;
  localparam int WH = (T_WHOLD  < 1) ? 1 : T_WHOLD;
  localparam int RA = (T_RACC   < 1) ? 1 : T_RACC;
  localparam int M1 = (WS > WP) ? WS : WP;
  localparam int M2 = (WH > RA) ? WH : RA;
  localparam int CMAX  = (M1 > M2) ? M1 : M2;
  localparam int CNT_W = $clog2(CMAX + 1);

  localparam logic [CNT_W-1:0] WS_C = CNT_W'(WS);
  localparam logic [CNT_W-1:0] WP_C = CNT_W'(WP);
  localparam logic [CNT_W-1:0] WH_C = CNT_W'(WH);
  localparam logic [CNT_W-1:0] RA_C = CNT_W'(RA);
  localparam logic [CNT_W-1:0] ONE  = CNT_W'(1);

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    W_SETUP  = 3'd1,
    W_PULSE  = 3'd2,
    W_HOLD   = 3'd3,
    R_ACCESS = 3'd4,
    DONE     = 3'd5
  } state_t;

  state_t             state_r;
  logic [CNT_W-1:0]   cnt_r;
  logic               ready_r;
  logic               busy_r;
  logic               rsp_valid_r;
  logic [DATA_W-1:0]  rsp_rdata_r;
  logic               ce_n_r;
  logic               oe_n_r;
  logic               we_n_r;
  logic [ADDR_W-1:0]  addr_r;
  logic [DATA_W-1:0]  wdata_r;
  logic               drive_r;

  // Controller FSM: state, wait-state counter and every registered output.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_r     <= IDLE;
      cnt_r       <= {CNT_W{1'b0}};
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_rdata_r <= {DATA_W{1'b0}};
      ce_n_r      <= 1'b1;
      oe_n_r      <= 1'b1;
      we_n_r      <= 1'b1;
      addr_r      <= {ADDR_W{1'b0}};
      wdata_r     <= {DATA_W{1'b0}};
      drive_r     <= 1'b0;
    end else begin
      case (state_r)
        IDLE: begin
          rsp_valid_r <= 1'b0;
          if (req_valid && ready_r) begin
            ready_r <= 1'b0;
            busy_r  <= 1'b1;
            ce_n_r  <= 1'b0;
            addr_r  <= req_addr;
            if (req_we) begin
              state_r <= W_SETUP;
              cnt_r   <= WS_C;
              wdata_r <= req_wdata;
              drive_r <= 1'b1;
            end else begin
              state_r <= R_ACCESS;
              cnt_r   <= RA_C;
              oe_n_r  <= 1'b0;
            end
          end else begin
            ready_r <= 1'b1;
          end
        end
        W_SETUP: begin
          if (cnt_r == ONE) begin
            state_r <= W_PULSE;
            cnt_r   <= WP_C;
            we_n_r  <= 1'b0;
          end else begin
            cnt_r <= cnt_r - ONE;
          end
        end
        W_PULSE: begin
          if (cnt_r == ONE) begin
            state_r <= W_HOLD;
            cnt_r   <= WH_C;
            we_n_r  <= 1'b1;
          end else begin
            cnt_r <= cnt_r - ONE;
          end
        end
        W_HOLD: begin
          if (cnt_r == ONE) begin
            state_r     <= DONE;
            drive_r     <= 1'b0;
            ce_n_r      <= 1'b1;
            rsp_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - ONE;
          end
        end
        R_ACCESS: begin
          // The bus is sampled on the edge that closes the last access cycle.
          if (cnt_r == ONE) begin
            state_r     <= DONE;
            rsp_rdata_r <= sram_data;
            oe_n_r      <= 1'b1;
            ce_n_r      <= 1'b1;
            rsp_valid_r <= 1'b1;
          end else begin
            cnt_r <= cnt_r - ONE;
          end
        end
        DONE: begin
          state_r     <= IDLE;
          rsp_valid_r <= 1'b0;
          busy_r      <= 1'b0;
          ready_r     <= 1'b1;
        end
        default: begin
          state_r     <= IDLE;
          cnt_r       <= {CNT_W{1'b0}};
          ready_r     <= 1'b0;
          busy_r      <= 1'b0;
          rsp_valid_r <= 1'b0;
          ce_n_r      <= 1'b1;
          oe_n_r      <= 1'b1;
          we_n_r      <= 1'b1;
          drive_r     <= 1'b0;
        end
      endcase
    end
  end

  assign req_ready = ready_r;
  assign busy      = busy_r;
  assign rsp_valid = rsp_valid_r;
  assign rsp_rdata = rsp_rdata_r;
  assign sram_ce_n = ce_n_r;
  assign sram_oe_n = oe_n_r;
  assign sram_we_n = we_n_r;
  assign sram_addr = addr_r;
  assign sram_data = drive_r ? wdata_r : {DATA_W{1'bz}};

  sram_ctrl_sync_chk u_chk (
    .clk       (clk),
    .rst       (rst),
    .ce_n      (ce_n_r),
    .oe_n      (oe_n_r),
    .we_n      (we_n_r),
    .drive     (drive_r),
    .rsp_valid (rsp_valid_r),
    .ready     (ready_r),
    .busy      (busy_r)
  );

endmodule

// File: tb/tb_sram_ctrl_sync.sv
// Randomised self-checking bench for sram_ctrl_sync: cycle-accurate expectations
// derived from the wait-state arithmetic, an SRAM memory model and a reference memory.
module tb_sram_ctrl_sync;

  localparam int DW = 16;
  localparam int AW = 18;
  localparam int TS = 1;
  localparam int TP = 2;
  localparam int TH = 1;
  localparam int TR = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst;
  logic          req_valid;
  logic          req_ready;
  logic          req_we;
  logic [AW-1:0] req_addr;
  logic [DW-1:0] req_wdata;
  logic          rsp_valid;
  logic [DW-1:0] rsp_rdata;
  logic          busy;
  logic          ce_n;
  logic          oe_n;
  logic          we_n;
  logic [AW-1:0] sram_addr;
  wire  [DW-1:0] sram_data;

  sram_ctrl_sync dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready), .req_we(req_we),
    .req_addr(req_addr), .req_wdata(req_wdata), .rsp_valid(rsp_valid), .rsp_rdata(rsp_rdata),
    .busy(busy), .sram_ce_n(ce_n), .sram_oe_n(oe_n), .sram_we_n(we_n),
    .sram_addr(sram_addr), .sram_data(sram_data)
  );

  // SRAM model plus a probe pattern driven whenever the controller must be off the bus
  logic [DW-1:0] mem [64] = '{default: 16'h0000};
  logic [DW-1:0] ref_mem [64];
  logic          exp_drv;
  logic [DW-1:0] probe;

  assign sram_data = (!ce_n && !oe_n) ? mem[sram_addr[5:0]] : (!exp_drv ? probe : 16'bz);

  always @(posedge clk) begin
    if (!ce_n && !we_n) mem[sram_addr[5:0]] <= sram_data;
  end

  // Second instance: narrow bus, zero WE pulse count, long read access
  logic          b_valid, b_ready, b_we, b_rsp, b_busy, b_ce_n, b_oe_n, b_we_n;
  logic [AW-1:0] b_addr_in, b_addr;
  logic [7:0]    b_wdata, b_rdata;
  logic [7:0]    b_mem = 8'h00;
  wire  [7:0]    b_data;

  sram_ctrl_sync #(.DATA_W(8), .ADDR_W(AW), .T_WSETUP(1), .T_WPULSE(0), .T_WHOLD(1), .T_RACC(4)) dut_b (
    .clk(clk), .rst(rst), .req_valid(b_valid), .req_ready(b_ready), .req_we(b_we),
    .req_addr(b_addr_in), .req_wdata(b_wdata), .rsp_valid(b_rsp), .rsp_rdata(b_rdata),
    .busy(b_busy), .sram_ce_n(b_ce_n), .sram_oe_n(b_oe_n), .sram_we_n(b_we_n),
    .sram_addr(b_addr), .sram_data(b_data)
  );

  assign b_data = (!b_ce_n && !b_oe_n) ? b_mem : 8'bz;

  always @(posedge clk) begin
    if (!b_ce_n && !b_we_n) b_mem <= b_data;
  end

  int            n_vec = 0;
  int            n_err = 0;
  logic [AW-1:0] last_addr;
  logic [DW-1:0] last_rdata;
  bit            prev_chain;

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic idle_cycle(input logic exp_ready);
    @(posedge clk); #1;
    exp_drv = 1'b0;
    @(negedge clk);
    check_eq("idle_ready", req_ready, exp_ready);
    check_eq("idle_busy", busy, 1'b0);
    check_eq("idle_rsp", rsp_valid, 1'b0);
    check_eq("idle_pins", {ce_n, oe_n, we_n}, 3'b111);
    check_eq("idle_addr", sram_addr, last_addr);
    check_eq("idle_rdata", rsp_rdata, last_rdata);
    check_eq("idle_bus", sram_data, probe);
  endtask

  // One transaction, checked cycle by cycle from the accept edge; abort_k>0 raises rst in that cycle.
  task automatic run_txn(input logic we, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                         input bit chain, input int abort_k);
    int n;
    int waits;
    logic [DW-1:0] exp_rd;
    logic [DW-1:0] exp_bus;
    req_valid = 1'b1;
    req_we    = we;
    req_addr  = addr;
    req_wdata = wdata;
    waits = 0;
    while (req_ready !== 1'b1 && waits < 20) begin
      @(posedge clk); #1;
      exp_drv = 1'b0;
      @(negedge clk);
      waits++;
    end
    check_eq("accept_ready", req_ready, 1'b1);
    if (prev_chain) check_eq("b2b_idle_gap", waits, 1);
    prev_chain = chain;
    if (req_ready !== 1'b1) return;
    n = we ? (TS + TP + TH + 1) : (TR + 1);
    exp_rd = ref_mem[addr[5:0]];
    if (we) begin
      ref_mem[addr[5:0]] = wdata;
      probe = ~wdata;
    end
    last_addr = addr;
    for (int k = 1; k <= n; k++) begin
      @(posedge clk); #1;
      exp_drv = we && (k <= n - 1);
      @(negedge clk);
      check_eq(we ? "wr_busy" : "rd_busy", busy, 1'b1);
      check_eq(we ? "wr_ready" : "rd_ready", req_ready, 1'b0);
      check_eq(we ? "wr_ce_n" : "rd_ce_n", ce_n, (k <= n - 1) ? 1'b0 : 1'b1);
      check_eq(we ? "wr_oe_n" : "rd_oe_n", oe_n, (!we && k <= TR) ? 1'b0 : 1'b1);
      check_eq(we ? "wr_we_n" : "rd_we_n", we_n, (we && k > TS && k <= TS + TP) ? 1'b0 : 1'b1);
      check_eq(we ? "wr_addr" : "rd_addr", sram_addr, addr);
      check_eq(we ? "wr_rsp" : "rd_rsp", rsp_valid, (k == n) ? 1'b1 : 1'b0);
      if (!we && k == n) last_rdata = exp_rd;
      check_eq(we ? "wr_rdata" : "rd_rdata", rsp_rdata, last_rdata);
      if (we && k <= n - 1) exp_bus = wdata;
      else if (!we && k <= TR) exp_bus = exp_rd;
      else exp_bus = probe;
      check_eq(we ? "wr_bus" : "rd_bus", sram_data, exp_bus);
      if (k == 1) begin
        req_valid = chain;
        req_we    = 1'($urandom);
        req_addr  = AW'($urandom);
        req_wdata = DW'($urandom);
      end
      if (k == abort_k) begin
        rst = 1'b1;
        prev_chain = 1'b0;
        break;
      end
    end
  endtask

  task automatic run_b(input logic we, input logic [7:0] wd, output int lat, output int low_cnt);
    int waits;
    b_valid = 1'b1; b_we = we; b_addr_in = 18'h00005; b_wdata = wd;
    waits = 0;
    lat = 0;
    low_cnt = 0;
    while (b_ready !== 1'b1 && waits < 20) begin
      @(negedge clk);
      waits++;
    end
    check_eq("b_accept_ready", b_ready, 1'b1);
    @(posedge clk);
    for (int k = 1; k <= 20; k++) begin
      @(negedge clk);
      if (k == 1) b_valid = 1'b0;
      if (we ? !b_we_n : !b_oe_n) low_cnt++;
      if (b_rsp) begin
        lat = k;
        break;
      end
    end
  endtask

  initial begin
    int lat;
    int lowc;
    logic          we_t;
    logic [AW-1:0] a_t;
    logic [DW-1:0] d_t;
    bit            ch_t;
    rst = 1'b1;
    req_valid = 1'b1; req_we = 1'b1; req_addr = 18'h00111; req_wdata = 16'hBEEF;
    b_valid = 1'b0; b_we = 1'b0; b_addr_in = 18'h00000; b_wdata = 8'h00;
    exp_drv = 1'b0; probe = 16'h5AA5;
    last_addr = 18'h00000; last_rdata = 16'h0000; prev_chain = 1'b0;
    for (int i = 0; i < 64; i++) ref_mem[i] = 16'h0000;

    // Reset held for three cycles with a request pending
    repeat (3) idle_cycle(1'b0);
    rst = 1'b0;
    idle_cycle(1'b1);
    req_valid = 1'b0;
    idle_cycle(1'b1);

    // Directed write, read-back, back-to-back read then write
    run_txn(1'b1, 18'h00012, 16'hA5C3, 1'b0, 0);
    idle_cycle(1'b1);
    run_txn(1'b0, 18'h00012, 16'h0000, 1'b0, 0);
    idle_cycle(1'b1);
    run_txn(1'b0, 18'h00012, 16'h0000, 1'b1, 0);
    run_txn(1'b1, 18'h00007, 16'h3C96, 1'b0, 0);
    idle_cycle(1'b1);

    // Reset during the WE pulse of a write to a location never read afterwards
    run_txn(1'b1, 18'h00028, 16'h1234, 1'b0, 2);
    last_addr = 18'h00000;
    last_rdata = 16'h0000;
    idle_cycle(1'b0);
    rst = 1'b0;
    idle_cycle(1'b1);
    idle_cycle(1'b1);
    run_txn(1'b0, 18'h00012, 16'h0000, 1'b0, 0);
    idle_cycle(1'b1);

    // Random mix of reads and writes, some back-to-back
    for (int t = 0; t < 40; t++) begin
      we_t = (t < 8) ? 1'b1 : 1'($urandom_range(0, 1));
      a_t  = AW'($urandom_range(0, 31));
      d_t  = DW'($urandom);
      ch_t = (t < 39) && ($urandom_range(0, 1) == 1);
      run_txn(we_t, a_t, d_t, ch_t, 0);
      if (!ch_t) repeat ($urandom_range(0, 2)) idle_cycle(1'b1);
    end
    req_valid = 1'b0;
    idle_cycle(1'b1);

    // Narrow instance: one-cycle WE pulse, read response in cycle 5
    run_b(1'b1, 8'hA7, lat, lowc);
    check_eq("b_wpulse_len", lowc, 1);
    check_eq("b_wr_rsp_cycle", lat, 4);
    repeat (2) @(negedge clk);
    run_b(1'b0, 8'h00, lat, lowc);
    check_eq("b_oe_len", lowc, 4);
    check_eq("b_rd_rsp_cycle", lat, 5);
    check_eq("b_rdata", b_rdata, 8'hA7);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

endmodule

// File: doc/sram_ctrl_sync.md
Name: sram_ctrl_sync

Overview:
- Clocked, parametrised controller for an asynchronous single-port SRAM. Generalises the earlier delay-based RAM controller.
- Accepts one read or write request at a time over a valid/ready handshake.
- Sequences CE/OE/WE and the tristate data bus, using programmable wait-state counts instead of `#` delays.
- Returns a one-cycle response pulse. Sits between the UART command logic and the external SRAM pins.

Parameters:
- DATA_W, 16, data bus width
- ADDR_W, 18, address width
- T_WSETUP, 1, cycles of address/data setup before the WE pulse (0 treated as 1)
- T_WPULSE, 2, cycles WE_n is held low (0 treated as 1)
- T_WHOLD, 1, cycles data is held after WE_n rises (0 treated as 1)
- T_RACC, 2, cycles OE_n is low before the read sample (0 treated as 1)

Ports:
- clk  in  1  system clock, all logic on rising edge
- rst  in  1  synchronous, active-high reset
- req_valid  in  1  request present
- req_ready  out  1  controller can accept a request
- req_we  in  1  1 = write, 0 = read
- req_addr  in  ADDR_W  request address
- req_wdata  in  DATA_W  write data
- rsp_valid  out  1  one-cycle completion pulse (reads and writes)
- rsp_rdata  out  DATA_W  read data, valid when rsp_valid follows a read
- busy  out  1  transaction in progress (state != IDLE)
- sram_ce_n  out  1  chip enable, active low
- sram_oe_n  out  1  output enable, active low
- sram_we_n  out  1  write enable, active low
- sram_addr  out  ADDR_W  SRAM address
- sram_data  inout  DATA_W  SRAM data bus; driven only in write states, otherwise high-Z

Behaviour:
- All outputs are registered. There are no combinational paths from req_* to sram_*.
- Reset values:
  - req_ready=0 during the reset cycle, 1 on the first cycle after reset deasserts
  - rsp_valid=0, rsp_rdata=0, busy=0
  - sram_ce_n=1, sram_oe_n=1, sram_we_n=1, sram_addr=0
  - sram_data released (high-Z)
- States: IDLE, W_SETUP, W_PULSE, W_HOLD, R_ACCESS, DONE. A single down-counter, sized for the largest T_*, times each state.
- Handshake:
  - Accept occurs on an edge with req_valid=1 and req_ready=1. req_ready=1 only in IDLE.
  - On accept, latch req_we, req_addr and req_wdata. Later changes on req_* have no effect.
  - req_valid held high while busy is accepted only once the controller returns to IDLE. Minimum one IDLE cycle between transactions.
- Timing convention: the accept edge is cycle 0; later cycle numbers count from it.
- Write path (IDLE→W_SETUP→W_PULSE→W_HOLD→DONE→IDLE):
  - W_SETUP (T_WSETUP cycles): ce_n=0, oe_n=1, we_n=1, addr and data driven.
  - W_PULSE (T_WPULSE cycles): we_n=0.
  - W_HOLD (T_WHOLD cycles): we_n=1, data still driven.
  - DONE: data released, ce_n=1, rsp_valid=1.
  - rsp_valid is high in cycle T_WSETUP+T_WPULSE+T_WHOLD+1 (default 5).
  - rsp_rdata is unchanged by writes.
- Read path (IDLE→R_ACCESS→DONE→IDLE):
  - R_ACCESS (T_RACC cycles): ce_n=0, oe_n=0, bus high-Z.
  - sram_data is sampled into rsp_rdata on the edge ending the last R_ACCESS cycle.
  - DONE: oe_n=1, ce_n=1, rsp_valid=1.
  - rsp_valid is high in cycle T_RACC+1 (default 3).
  - rsp_rdata then holds its value until the next read completes.
- Bus contention rules:
  - The controller never drives sram_data while oe_n=0.
  - oe_n and we_n are never low in the same cycle.
  - A write following a read always has at least one cycle (DONE/IDLE) with oe_n=1 before data is driven.
- sram_addr holds the latched address from W_SETUP/R_ACCESS through DONE, and keeps its value in IDLE.
- Reset mid-operation: on the reset edge the controller goes to IDLE and all outputs take their reset values, including we_n=1 and the bus released. No rsp_valid is issued for the aborted transaction.
- The wait-state counter reloads on every state entry. There is no wrap-around or underflow path: counter==1 is the exit condition.

Test Plan:
- Reset: assert rst for 3 cycles during a pending req_valid → all outputs at reset values, no accept; req_ready=1 on the first cycle after deassertion.
- Default write, addr=0x00012, data=0xA5C3:
  - ce_n low in cycles 1–4; we_n low exactly in cycles 2–3
  - bus = 0xA5C3 in cycles 1–4; rsp_valid high only in cycle 5
  - req_ready=0 in cycles 1–5
- Read back addr=0x00012 with an SRAM model returning 0xA5C3 → oe_n low in cycles 1–2, bus high-Z throughout, rsp_valid high in cycle 3 with rsp_rdata=0xA5C3.
- Back-to-back read then write with req_valid held high → second accept occurs only in IDLE; no cycle has bus driven with oe_n=0; exactly one rsp_valid per transaction.
- rst asserted in cycle 2 of a write (we_n low) → we_n=1 and bus high-Z from the next edge, no rsp_valid; a following read completes normally.
- Parameters T_WPULSE=0, T_RACC=4, DATA_W=8 → we_n low exactly 1 cycle; read rsp_valid in cycle 5; sampled data is the 8-bit bus value.
